// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg: shared encodings for the edge event arbiter
package edge_arb_pkg;
  localparam logic [1:0] SEL_OFF  = 2'b00;
  localparam logic [1:0] SEL_RISE = 2'b01;
  localparam logic [1:0] SEL_FALL = 2'b10;
  localparam logic [1:0] SEL_BOTH = 2'b11;
  localparam logic EVT_RISE = 1'b1;
  localparam logic EVT_FALL = 1'b0;
  typedef enum logic {ST_IDLE, ST_OFFER} state_t;
endpackage

// File: rtl/edge_arb_chan.sv
// edge_arb_chan: per-channel input stage, edge detect and one-deep pending event
// EDGE_ARB_SYNC_EN selects a two-flop synchronizer instead of a single sampling register.
module edge_arb_chan
  import edge_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic [1:0] sel,
  input  logic       clr,
  input  logic       ovf_clr,
  output logic       pending,
  output logic       etype,
  output logic       ovf
);
  logic stage, prev, rise, qual, take;
`ifdef EDGE_ARB_SYNC_EN
  logic meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) {meta, stage} <= '0;
    else {meta, stage} <= {sig, meta};
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) stage <= 1'b0;
    else stage <= sig;
`endif
  always_comb begin
    rise = stage & ~prev;
    qual = (stage != prev) && ((sel & (rise ? SEL_RISE : SEL_FALL)) != SEL_OFF);
    take = qual & (~pending | clr);
  end
  // a transfer in the same cycle frees the slot, so the new edge is kept instead of overflowing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev    <= 1'b0;
      pending <= 1'b0;
      etype   <= EVT_FALL;
      ovf     <= 1'b0;
    end else begin
      prev    <= stage;
      pending <= take ? 1'b1 : (clr ? 1'b0 : pending);
      etype   <= take ? (rise ? EVT_RISE : EVT_FALL) : etype;
      ovf     <= (qual & pending & ~clr) ? 1'b1 : (ovf_clr ? 1'b0 : ovf);
    end
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: round-robin serializer of per-channel edge events onto valid/ready
// EDGE_ARB_SYNC_EN adds a two-flop synchronizer per input (one extra cycle of latency).
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   sig_in,
  input  logic [2*N-1:0] edge_sel,
  input  logic           evt_ready,
  input  logic           ovf_clr,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  output logic           evt_type,
  output logic [N-1:0]   ovf
);
  state_t state;
  logic [N-1:0] pending, etype_v, clr_vec, mask;
  logic [IDW-1:0] rr_ptr, nxt_ptr, start, win;
  logic xfer, any;
  int j;
  for (genvar i = 0; i < N; i++) begin : g_chan
    edge_arb_chan u_chan (
      .clk(clk), .rst(rst), .sig(sig_in[i]), .sel(edge_sel[2*i +: 2]),
      .clr(clr_vec[i]), .ovf_clr(ovf_clr),
      .pending(pending[i]), .etype(etype_v[i]), .ovf(ovf[i])
    );
  end
  // on a transfer the next winner is searched from evt_id+1 with the departing channel masked out
  always_comb begin
    xfer    = evt_valid & evt_ready;
    clr_vec = xfer ? (N'(1) << evt_id) : '0;
    nxt_ptr = (int'(evt_id) == N - 1) ? '0 : evt_id + 1'b1;
    start   = xfer ? nxt_ptr : rr_ptr;
    mask    = pending & ~clr_vec;
    any     = |mask;
    win     = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(start) + k) % N;
      if (mask[j[IDW-1:0]]) win = j[IDW-1:0];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= ST_IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= EVT_FALL;
      rr_ptr    <= '0;
    end else if (state == ST_IDLE || xfer) begin
      if (xfer) rr_ptr <= nxt_ptr;
      evt_valid <= any;
      state     <= any ? ST_OFFER : ST_IDLE;
      if (any) begin
        evt_id   <= win;
        evt_type <= etype_v[win];
      end
    end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed table-driven checks of the edge event arbiter (N=4)
module tb_edge_event_arbiter;
  import edge_arb_pkg::*;
`ifdef EDGE_ARB_SYNC_EN
  localparam int L = 4;
`else
  localparam int L = 3;
`endif
  logic clk = 1'b0, rst = 1'b1, evt_ready = 1'b0, ovf_clr = 1'b0;
  logic [3:0] sig_in = '0;
  logic [7:0] edge_sel = '0;
  logic evt_valid, evt_type;
  logic [1:0] evt_id;
  logic [3:0] ovf;
  int tests = 0, fails = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] sig;
    logic [7:0] sel;
    logic       rdy;
    logic       clr;
    int         n;
    logic       ev;
    logic [1:0] eid;
    logic       et;
    logic [3:0] eovf;
  } vec_t;
  vec_t v[$];

  edge_event_arbiter #(.N(4)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .edge_sel(edge_sel),
    .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid),
    .evt_id(evt_id), .evt_type(evt_type), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic ev, input logic [1:0] eid, input logic et,
                     input logic [3:0] eovf);
    tests++;
    if (evt_valid !== ev || ovf !== eovf || (ev && (evt_id !== eid || evt_type !== et))) begin
      fails++;
      $display("FAIL %s: got valid=%0b id=%0d type=%0b ovf=%b, want valid=%0b id=%0d type=%0b ovf=%b",
               nm, evt_valid, evt_id, evt_type, ovf, ev, eid, et, eovf);
    end
  endtask

  task automatic add(input string nm, input logic r, input logic [3:0] s, input logic [7:0] se,
                     input logic rd, input logic c, input int n, input logic ev,
                     input logic [1:0] eid, input logic et, input logic [3:0] eovf);
    vec_t t;
    t = '{nm, r, s, se, rd, c, n, ev, eid, et, eovf};
    v.push_back(t);
  endtask

  initial begin
    add("a_rst",    1, 4'b0000, 8'h00, 0, 0, 2,     0, 0, 0, 4'b0000);
    add("a_quiet",  0, 4'b0100, 8'h10, 1, 0, L - 1, 0, 0, 0, 4'b0000);
    add("a_evt",    0, 4'b0100, 8'h10, 1, 0, 1,     1, 2, 1, 4'b0000);
    add("a_once",   0, 4'b0100, 8'h10, 1, 0, 1,     0, 0, 0, 4'b0000);
    add("b_rst",    1, 4'b0000, 8'h00, 0, 0, 2,     0, 0, 0, 4'b0000);
    add("b_id0",    0, 4'b1111, 8'hFF, 1, 0, L,     1, 0, 1, 4'b0000);
    add("b_id1",    0, 4'b1111, 8'hFF, 1, 0, 1,     1, 1, 1, 4'b0000);
    add("b_id2",    0, 4'b1111, 8'hFF, 1, 0, 1,     1, 2, 1, 4'b0000);
    add("b_id3",    0, 4'b1111, 8'hFF, 1, 0, 1,     1, 3, 1, 4'b0000);
    add("b_idle",   0, 4'b1111, 8'hFF, 1, 0, 1,     0, 0, 0, 4'b0000);
    add("b_low",    0, 4'b0000, 8'h00, 1, 0, L + 2, 0, 0, 0, 4'b0000);
    add("b_wrap0",  0, 4'b0011, 8'hFF, 1, 0, L,     1, 0, 1, 4'b0000);
    add("b_wrap1",  0, 4'b0011, 8'hFF, 1, 0, 1,     1, 1, 1, 4'b0000);
    add("b_end",    0, 4'b0011, 8'hFF, 1, 0, 1,     0, 0, 0, 4'b0000);
    add("c_rst",    1, 4'b0000, 8'h00, 0, 0, 2,     0, 0, 0, 4'b0000);
    add("c_offer",  0, 4'b0010, 8'hFF, 0, 0, L,     1, 1, 1, 4'b0000);
    add("c_ovf",    0, 4'b0000, 8'hFF, 0, 0, L,     1, 1, 1, 4'b0010);
    add("c_clr",    0, 4'b0000, 8'hFF, 0, 1, 1,     1, 1, 1, 4'b0000);
    add("c_xfer",   0, 4'b0000, 8'hFF, 1, 0, 1,     0, 0, 0, 4'b0000);
    add("c_none",   0, 4'b0000, 8'hFF, 1, 0, 2,     0, 0, 0, 4'b0000);
    add("d_rst",    1, 4'b0000, 8'h00, 0, 0, 2,     0, 0, 0, 4'b0000);
    add("d_offer",  0, 4'b0001, 8'hFF, 0, 0, L,     1, 0, 1, 4'b0000);
    add("d_fall",   0, 4'b0000, 8'hFF, 0, 0, L - 2, 1, 0, 1, 4'b0000);
    add("d_xfer",   0, 4'b0000, 8'hFF, 1, 0, 1,     0, 0, 0, 4'b0000);
    add("d_new",    0, 4'b0000, 8'hFF, 1, 0, 1,     1, 0, 0, 4'b0000);
    add("d_end",    0, 4'b0000, 8'hFF, 1, 0, 1,     0, 0, 0, 4'b0000);
    add("e_rst",    1, 4'b0000, 8'h00, 0, 0, 2,     0, 0, 0, 4'b0000);
    add("e_rise",   0, 4'b1000, 8'h80, 1, 0, L,     0, 0, 0, 4'b0000);
    add("e_hold",   0, 4'b1000, 8'h80, 1, 0, 2,     0, 0, 0, 4'b0000);
    add("e_fall",   0, 4'b0000, 8'h80, 1, 0, L,     1, 3, 0, 4'b0000);
    add("e_once",   0, 4'b0000, 8'h80, 1, 0, 1,     0, 0, 0, 4'b0000);
    add("e_off_r",  0, 4'b1000, 8'h00, 1, 0, L + 1, 0, 0, 0, 4'b0000);
    add("e_off_f",  0, 4'b0000, 8'h00, 1, 0, L + 1, 0, 0, 0, 4'b0000);
    add("f_rst",    1, 4'b0000, 8'h00, 0, 0, 2,     0, 0, 0, 4'b0000);
    add("f_offer",  0, 4'b0111, 8'hFF, 0, 0, L,     1, 0, 1, 4'b0000);
    foreach (v[i]) begin
      rst       = v[i].rst;
      sig_in    = v[i].sig;
      edge_sel  = v[i].sel;
      evt_ready = v[i].rdy;
      ovf_clr   = v[i].clr;
      step(v[i].n);
      chk(v[i].name, v[i].ev, v[i].eid, v[i].et, v[i].eovf);
    end
    rst = 1'b1;
    #1;
    chk("f_async_rst", 0, 0, 0, 4'b0000);
    sig_in    = 4'b0101;
    evt_ready = 1'b1;
    step(2);
    rst = 1'b0;
    step(L);
    chk("f_held0", 1, 0, 1, 4'b0000);
    step(1);
    chk("f_held2", 1, 2, 1, 4'b0000);
    step(1);
    chk("f_done", 0, 0, 0, 4'b0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
